// File: rtl/ones_count_scheduler_pkg.sv
// Shared scheduler state type, default geometry and timer sizing helper
// for the ones-count scheduler.
package ones_cnt_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } sched_state_t;

    localparam int DEF_NREQ   = 4;
    localparam int DEF_WIDTH  = 127;
    localparam int DEF_CNTW   = 7;
    localparam int DEF_SETTLE = 8;

    // Timer holds SETTLE-1; keep at least one bit so SETTLE=1 still elaborates.
    function automatic int timer_width(input int settle);
        return (settle > 1) ? $clog2(settle) : 1;
    endfunction

endpackage

// File: rtl/ones_count_scheduler_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr
// (wrapping) wins; the pointer register lives in the scheduler.
module rr_arbiter
    import ones_cnt_pkg::*;
#(
    parameter int NREQ = DEF_NREQ
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] ptr,
    output logic [NREQ-1:0]         grant,
    output logic [$clog2(NREQ)-1:0] grant_idx
);

    localparam int IDXW = $clog2(NREQ);

    logic            found_s;
    logic            hit_s;
    logic [IDXW-1:0] idx_s;
    logic [IDXW-1:0] cand_s;
    logic [IDXW:0]   sum_s;

    // Walk NREQ positions starting at ptr; the first pending requester is latched.
    always_comb begin
        found_s = 1'b0;
        hit_s   = 1'b0;
        idx_s   = '0;
        cand_s  = '0;
        sum_s   = '0;
        for (int k = 0; k < NREQ; k++) begin
            sum_s   = {1'b0, ptr} + (IDXW+1)'(k);
            cand_s  = (sum_s >= (IDXW+1)'(NREQ)) ? IDXW'(sum_s - (IDXW+1)'(NREQ))
                                                 : sum_s[IDXW-1:0];
            hit_s   = req[cand_s] & ~found_s;
            idx_s   = hit_s ? cand_s : idx_s;
            found_s = found_s | req[cand_s];
        end
    end

    // Decode the winning index into a one-hot grant, empty when nobody asks.
    always_comb begin
        grant = '0;
        if (found_s) begin
            grant[idx_s] = 1'b1;
        end else begin
            grant = '0;
        end
    end

    assign grant_idx = idx_s;

endmodule

// File: rtl/ones_count_scheduler.sv
// Time-shares one external combinational ones counter between NREQ requesters:
// round-robin grant, registered operand, fixed settle wait, held response.
module ones_count_scheduler_cfg_chk #(
    parameter int NREQ   = 4,
    parameter int WIDTH  = 127,
    parameter int CNTW   = 7,
    parameter int SETTLE = 8
);
    if (NREQ < 2) begin : g_bad_nreq
        $error("ones_count_scheduler: NREQ must be at least 2");
    end
    if (CNTW < $clog2(WIDTH + 1)) begin : g_bad_cntw
        $error("ones_count_scheduler: CNTW too narrow for WIDTH");
    end
    if (SETTLE < 1) begin : g_bad_settle
        $error("ones_count_scheduler: SETTLE must be at least 1");
    end
endmodule

module ones_count_scheduler
    import ones_cnt_pkg::*;
#(
    parameter int NREQ   = DEF_NREQ,
    parameter int WIDTH  = DEF_WIDTH,
    parameter int CNTW   = DEF_CNTW,
    parameter int SETTLE = DEF_SETTLE
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*WIDTH-1:0]   req_data,
    output logic [NREQ-1:0]         req_ready,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [$clog2(NREQ)-1:0] rsp_id,
    output logic [CNTW-1:0]         rsp_count,
    output logic [WIDTH-1:0]        cnt_operand,
    input  logic [CNTW-1:0]         cnt_result
);

    localparam int IDXW = $clog2(NREQ);
    localparam int TW   = timer_width(SETTLE);
    localparam logic [TW-1:0] TIMER_LOAD = TW'(SETTLE - 1);

    sched_state_t     state_r, state_s;
    logic [IDXW-1:0]  rr_ptr_r, rr_ptr_s;
    logic [TW-1:0]    timer_r, timer_s;
    logic             rsp_valid_r, rsp_valid_s;
    logic [IDXW-1:0]  rsp_id_r, rsp_id_s;
    logic [CNTW-1:0]  rsp_count_r, rsp_count_s;
    logic [WIDTH-1:0] cnt_operand_r, cnt_operand_s;

    logic [NREQ-1:0]  arb_grant_s;
    logic [IDXW-1:0]  arb_idx_s;
    logic [WIDTH-1:0] operand_s [NREQ];
    logic             any_req_s;
    logic             offer_s;

    ones_count_scheduler_cfg_chk #(
        .NREQ   (NREQ),
        .WIDTH  (WIDTH),
        .CNTW   (CNTW),
        .SETTLE (SETTLE)
    ) u_cfg_chk ();

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_arb (
        .req       (req_valid),
        .ptr       (rr_ptr_r),
        .grant     (arb_grant_s),
        .grant_idx (arb_idx_s)
    );

    // Split the flat operand bus into one word per requester.
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            operand_s[i] = req_data[i*WIDTH +: WIDTH];
        end
    end

    assign any_req_s = |req_valid;
    // The grant is only offered from IDLE, and never while reset is being applied.
    assign offer_s   = (state_r == IDLE) & any_req_s & ~rst;
    assign req_ready = offer_s ? arb_grant_s : '0;

    // Next-state and datapath updates for the IDLE -> WAIT -> RESP cycle.
    always_comb begin
        state_s       = state_r;
        rr_ptr_s      = rr_ptr_r;
        timer_s       = timer_r;
        rsp_valid_s   = rsp_valid_r;
        rsp_id_s      = rsp_id_r;
        rsp_count_s   = rsp_count_r;
        cnt_operand_s = cnt_operand_r;
        case (state_r)
            IDLE: begin
                rsp_valid_s = 1'b0;
                if (any_req_s) begin
                    cnt_operand_s = operand_s[arb_idx_s];
                    rsp_id_s      = arb_idx_s;
                    timer_s       = TIMER_LOAD;
                    rr_ptr_s      = (arb_idx_s == IDXW'(NREQ - 1)) ? '0
                                                                   : arb_idx_s + IDXW'(1);
                    state_s       = WAIT;
                end else begin
                    state_s = IDLE;
                end
            end
            WAIT: begin
                if (timer_r != '0) begin
                    timer_s = timer_r - TW'(1);
                end else begin
                    rsp_count_s = cnt_result;
                    rsp_valid_s = 1'b1;
                    state_s     = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_s = 1'b0;
                    state_s     = IDLE;
                end else begin
                    state_s = RESP;
                end
            end
            default: begin
                rsp_valid_s = 1'b0;
                timer_s     = '0;
                state_s     = IDLE;
            end
        endcase
    end

    // State and output registers; reset discards any transaction in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= IDLE;
            rr_ptr_r      <= '0;
            timer_r       <= '0;
            rsp_valid_r   <= 1'b0;
            rsp_id_r      <= '0;
            rsp_count_r   <= '0;
            cnt_operand_r <= '0;
        end else begin
            state_r       <= state_s;
            rr_ptr_r      <= rr_ptr_s;
            timer_r       <= timer_s;
            rsp_valid_r   <= rsp_valid_s;
            rsp_id_r      <= rsp_id_s;
            rsp_count_r   <= rsp_count_s;
            cnt_operand_r <= cnt_operand_s;
        end
    end

    assign rsp_valid   = rsp_valid_r;
    assign rsp_id      = rsp_id_r;
    assign rsp_count   = rsp_count_r;
    assign cnt_operand = cnt_operand_r;

endmodule

// File: tb/tb_ones_count_scheduler.sv
// Self-checking bench for ones_count_scheduler with a delayed ones-counter
// stand-in, directed vectors, corner sequences and a randomized pending-set model.
module tb_ones_count_scheduler;

    localparam int NREQ   = 4;
    localparam int WIDTH  = 127;
    localparam int CNTW   = 7;
    localparam int SETTLE = 8;
    localparam int IDXW   = $clog2(NREQ);
    localparam int LAT    = SETTLE + 1;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [NREQ-1:0]       req_valid = '0;
    logic [NREQ*WIDTH-1:0] req_data = '0;
    logic [NREQ-1:0]       req_ready;
    logic                  rsp_valid;
    logic                  rsp_ready = 1'b0;
    logic [IDXW-1:0]       rsp_id;
    logic [CNTW-1:0]       rsp_count;
    logic [WIDTH-1:0]      cnt_operand;
    logic [CNTW-1:0]       cnt_result = '0;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc_n = 0;

    typedef struct {
        int               id;
        logic [WIDTH-1:0] data;
        logic [CNTW-1:0]  exp_count;
    } vec_t;

    vec_t vecs [6];

    ones_count_scheduler #(
        .NREQ (NREQ), .WIDTH (WIDTH), .CNTW (CNTW), .SETTLE (SETTLE)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_id      (rsp_id),
        .rsp_count   (rsp_count),
        .cnt_operand (cnt_operand),
        .cnt_result  (cnt_result)
    );

    always #50 clk = ~clk;

    // Counter stand-in: wrong value while rippling, true popcount 7.5 clocks later.
    always @(cnt_operand) begin
        cnt_result = CNTW'($countones(cnt_operand)) ^ 7'h5A;
        #750;
        cnt_result = CNTW'($countones(cnt_operand));
    end

    initial begin
        #(100 * 50000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc_n);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        cyc_n++;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b0;
        repeat (2) cyc();
        rst = 1'b0;
    endtask

    function automatic logic [WIDTH-1:0] rand_word();
        logic [127:0] w;
        int sel;
        sel = $urandom_range(0, 5);
        w = {$urandom, $urandom, $urandom, $urandom};
        if (sel == 0) w = '0;
        if (sel == 1) w = '1;
        return w[WIDTH-1:0];
    endfunction

    // Round-robin rule: first pending requester at or after the pointer, wrapping.
    function automatic int pick(input logic [NREQ-1:0] m, input int p);
        for (int k = 0; k < NREQ; k++) begin
            if (m[(p + k) % NREQ]) return (p + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic single_txn(input int id, input logic [WIDTH-1:0] data,
                              input logic [CNTW-1:0] exp_count, input string tag);
        int t0;
        int waited;
        for (int i = 0; i < NREQ; i++) req_data[i*WIDTH +: WIDTH] = rand_word();
        req_data[id*WIDTH +: WIDTH] = data;
        req_valid = NREQ'(1) << id;
        rsp_ready = 1'b1;
        #1;
        waited = 0;
        while (req_ready == '0 && waited < 30) begin
            cyc(); #1; waited++;
        end
        check({tag, "_grant"}, WIDTH'(req_ready), WIDTH'(NREQ'(1) << id));
        t0 = cyc_n;
        cyc();
        req_valid = '0;
        #1;
        while (!rsp_valid && (cyc_n - t0) < 40) begin
            cyc(); #1;
        end
        check({tag, "_latency"}, WIDTH'(cyc_n - t0), WIDTH'(LAT));
        check({tag, "_id"}, WIDTH'(rsp_id), WIDTH'(id));
        check({tag, "_count"}, WIDTH'(rsp_count), WIDTH'(exp_count));
        check({tag, "_operand"}, cnt_operand, data);
        cyc(); #1;
        check({tag, "_released"}, WIDTH'(rsp_valid), WIDTH'(1'b0));
    endtask

    initial begin
        logic [NREQ-1:0]  pend;
        logic [WIDTH-1:0] pdata [NREQ];
        logic [WIDTH-1:0] bp_data;
        int               mptr, g, t0, hold, busy_bad, ng, j;
        int               gidx [5];
        int               gcyc [5];

        vecs[0] = '{2, 127'h5, 7'd2};
        vecs[1] = '{1, {WIDTH{1'b1}}, 7'd127};
        vecs[2] = '{3, 127'h0, 7'd0};
        vecs[3] = '{0, 127'hFF00_FF00, 7'd16};
        vecs[4] = '{2, 127'h4000_0000_0000_0000_0000_0000_0000_0001, 7'd2};
        vecs[5] = '{1, 127'h2AAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA, 7'd63};

        // Reset held two cycles with every requester asking.
        rst = 1'b1; req_valid = '1; rsp_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            cyc(); #1;
            check("rst_req_ready", WIDTH'(req_ready), '0);
            check("rst_rsp_valid", WIDTH'(rsp_valid), '0);
            check("rst_cnt_operand", cnt_operand, '0);
        end
        check("rst_rsp_id", WIDTH'(rsp_id), '0);
        check("rst_rsp_count", WIDTH'(rsp_count), '0);
        rst = 1'b0; req_valid = '0;
        cyc();

        for (int v = 0; v < 6; v++) begin
            single_txn(vecs[v].id, vecs[v].data, vecs[v].exp_count, $sformatf("vec%0d", v));
        end

        // Fairness: all four held asking, consumer always ready.
        do_reset();
        for (int i = 0; i < NREQ; i++) req_data[i*WIDTH +: WIDTH] = rand_word();
        req_valid = '1; rsp_ready = 1'b1;
        ng = 0;
        for (int k = 0; k < 5; k++) begin gidx[k] = -1; gcyc[k] = -100; end
        for (int c = 0; c < 80 && ng < 5; c++) begin
            #1;
            if (req_ready != '0) begin
                check("fair_onehot", WIDTH'($countones(req_ready)), WIDTH'(1));
                for (int b = NREQ - 1; b >= 0; b--) if (req_ready[b]) gidx[ng] = b;
                gcyc[ng] = cyc_n;
                ng++;
            end
            cyc();
        end
        check("fair_grant_total", WIDTH'(ng), WIDTH'(5));
        for (int k = 0; k < 5; k++) begin
            check($sformatf("fair_order%0d", k), WIDTH'(gidx[k]), WIDTH'(k % NREQ));
            if (k > 0) check($sformatf("fair_gap%0d", k), WIDTH'(gcyc[k] - gcyc[k-1]), WIDTH'(SETTLE + 2));
        end

        // Backpressure: response held 20 cycles with others pending.
        do_reset();
        bp_data = 127'h1234_5678;
        req_data[1*WIDTH +: WIDTH] = bp_data;
        req_valid = 4'b0010; rsp_ready = 1'b0;
        #1;
        check("bp_grant", WIDTH'(req_ready), WIDTH'(4'b0010));
        t0 = cyc_n;
        cyc(); req_valid = '0; #1;
        while (!rsp_valid && (cyc_n - t0) < 40) begin cyc(); #1; end
        check("bp_latency", WIDTH'(cyc_n - t0), WIDTH'(LAT));
        req_valid = 4'b1101;
        for (int c = 0; c < 20; c++) begin
            #1;
            check("bp_valid", WIDTH'(rsp_valid), WIDTH'(1'b1));
            check("bp_id", WIDTH'(rsp_id), WIDTH'(1));
            check("bp_count", WIDTH'(rsp_count), WIDTH'($countones(bp_data)));
            check("bp_no_ready", WIDTH'(req_ready), '0);
            cyc();
        end
        rsp_ready = 1'b1; #1;
        check("bp_release_no_ready", WIDTH'(req_ready), '0);
        cyc(); rsp_ready = 1'b0; #1;
        check("bp_resume_grant", WIDTH'(req_ready), WIDTH'(4'b0100));
        check("bp_resume_idle", WIDTH'(rsp_valid), '0);

        // Reset while WAIT timer reads 3: transaction must vanish.
        do_reset();
        req_data[2*WIDTH +: WIDTH] = '1;
        req_valid = 4'b0100; rsp_ready = 1'b1;
        #1;
        check("mid_grant", WIDTH'(req_ready), WIDTH'(4'b0100));
        cyc(); req_valid = '0;
        repeat (4) cyc();
        rst = 1'b1; req_valid = '1; #1;
        check("mid_rst_no_ready", WIDTH'(req_ready), '0);
        cyc(); rst = 1'b0; req_valid = '0; #1;
        check("mid_operand", cnt_operand, '0);
        check("mid_rsp_id", WIDTH'(rsp_id), '0);
        check("mid_rsp_count", WIDTH'(rsp_count), '0);
        busy_bad = 0;
        for (int c = 0; c < 15; c++) begin
            if (rsp_valid) busy_bad++;
            cyc(); #1;
        end
        check("mid_no_rsp", WIDTH'(busy_bad), '0);
        req_valid = '1; #1;
        check("mid_next_grant", WIDTH'(req_ready), WIDTH'(4'b0001));

        // Randomized traffic against the pending-set model.
        do_reset();
        mptr = 0; pend = '0;
        for (int i = 0; i < NREQ; i++) pdata[i] = '0;
        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!pend[i] && $urandom_range(0, 1) == 1) begin
                    pend[i] = 1'b1; pdata[i] = rand_word();
                end else if (pend[i] && $urandom_range(0, 7) == 0) begin
                    pend[i] = 1'b0;
                end
            end
            if (pend == '0) begin
                j = $urandom_range(0, NREQ - 1);
                pend[j] = 1'b1; pdata[j] = rand_word();
            end
            for (int i = 0; i < NREQ; i++) req_data[i*WIDTH +: WIDTH] = pdata[i];
            req_valid = pend; rsp_ready = 1'b0;
            #1;
            g = pick(pend, mptr);
            check("rand_grant", WIDTH'(req_ready), WIDTH'(NREQ'(1) << g));
            mptr = (g + 1) % NREQ;
            pend[g] = 1'b0;
            t0 = cyc_n;
            cyc(); req_valid = pend; #1;
            busy_bad = 0;
            while (!rsp_valid && (cyc_n - t0) < 40) begin
                if (req_ready != '0) busy_bad++;
                cyc(); #1;
            end
            check("rand_latency", WIDTH'(cyc_n - t0), WIDTH'(LAT));
            check("rand_busy_no_ready", WIDTH'(busy_bad), '0);
            check("rand_id", WIDTH'(rsp_id), WIDTH'(g));
            check("rand_count", WIDTH'(rsp_count), WIDTH'($countones(pdata[g])));
            check("rand_operand", cnt_operand, pdata[g]);
            hold = $urandom_range(0, 3);
            for (int h = 0; h < hold; h++) begin cyc(); #1; end
            check("rand_hold_valid", WIDTH'(rsp_valid), WIDTH'(1'b1));
            check("rand_hold_count", WIDTH'(rsp_count), WIDTH'($countones(pdata[g])));
            rsp_ready = 1'b1;
            cyc();
            rsp_ready = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
